// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if
//   Groups the read, write, issue and scoreboard signals between the
//   decode/writeback stages (master) and the register file (slave).
//   Read side  : rs, rt -> regA, regB, rsPending, rtPending
//   Write side : wrEn0/wrAddr0/wrData0 (ALU), wrEn1/wrAddr1/wrData1 (load)
//   Issue side : issueEn/issueAddr -> pendingCount
interface regfile_scoreboard_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic [DATA_W-1:0] regA;
   logic [DATA_W-1:0] regB;
   logic              rsPending;
   logic              rtPending;
   logic              wrEn0;
   logic [ADDR_W-1:0] wrAddr0;
   logic [DATA_W-1:0] wrData0;
   logic              wrEn1;
   logic [ADDR_W-1:0] wrAddr1;
   logic [DATA_W-1:0] wrData1;
   logic              issueEn;
   logic [ADDR_W-1:0] issueAddr;
   logic [ADDR_W:0]   pendingCount;

   modport master (
      output rs, rt, wrEn0, wrAddr0, wrData0, wrEn1, wrAddr1, wrData1,
             issueEn, issueAddr,
      input  regA, regB, rsPending, rtPending, pendingCount
   );

   modport slave (
      input  rs, rt, wrEn0, wrAddr0, wrData0, wrEn1, wrAddr1, wrData1,
             issueEn, issueAddr,
      output regA, regB, rsPending, rtPending, pendingCount
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file with two combinational read ports, two synchronous write
//   ports (port 1 wins on address conflict), optional write-to-read bypass,
//   optional hardwired-zero register 0, and a per-register pending-write
//   scoreboard with a registered popcount.
//   Ports: clk, reset (synchronous, active high), bus (slave modport of
//   regfile_scoreboard_if carrying all read/write/issue signals).

// One read port: bypass selection, zero register and pending masking.
// Write enables arriving here are already qualified (zero-register writes
// removed), so a hit never occurs on a dropped write.
module regfile_scoreboard_rdport #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] stored_i,
   input  logic              pend_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] wa0_i,
   input  logic [DATA_W-1:0] wd0_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] wa1_i,
   input  logic [DATA_W-1:0] wd1_i,
   output logic [DATA_W-1:0] data_o,
   output logic              pend_o
);
   logic hit0, hit1;

   always_comb begin
      hit0   = BYPASS && we0_i && (wa0_i == addr_i);
      hit1   = BYPASS && we1_i && (wa1_i == addr_i);
      data_o = stored_i;
      if (hit0) data_o = wd0_i;
      if (hit1) data_o = wd1_i;        // port 1 overrides port 0
      if (ZERO_REG && (addr_i == '0)) data_o = '0;
      // A write landing this cycle retires the producer, so decode may
      // consume the forwarded value without stalling.
      pend_o = pend_i & ~(hit0 | hit1);
   end
endmodule

module regfile_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_scoreboard_if.slave  bus
);
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int NUM_RD = 2;

   logic [DEPTH-1:0][DATA_W-1:0] mem_q;
   logic [DEPTH-1:0]             pend_q, pend_d;
   logic [ADDR_W:0]              cnt_q, cnt_d;

   // Qualified enables: accesses to register 0 vanish when it is hardwired.
   logic we0, we1, iss;
   assign we0 = bus.wrEn0   & ~(ZERO_REG && (bus.wrAddr0   == '0));
   assign we1 = bus.wrEn1   & ~(ZERO_REG && (bus.wrAddr1   == '0));
   assign iss = bus.issueEn & ~(ZERO_REG && (bus.issueAddr == '0));

   // Storage; the later nonblocking assignment gives port 1 priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q <= '0;
      end else begin
         if (we0) mem_q[bus.wrAddr0] <= bus.wrData0;
         if (we1) mem_q[bus.wrAddr1] <= bus.wrData1;
      end
   end

   // Scoreboard next state. Clears first, then the set, so an issue to an
   // address being written this cycle leaves the bit set.
   logic inc, dec0, dec1;

   always_comb begin
      pend_d = pend_q;
      if (we0) pend_d[bus.wrAddr0] = 1'b0;
      if (we1) pend_d[bus.wrAddr1] = 1'b0;
      if (iss) pend_d[bus.issueAddr] = 1'b1;

      // Count only real bit transitions; a dual-port write to one pending
      // address decrements once, and a clear overridden by an issue not at all.
      inc  = iss & ~pend_q[bus.issueAddr];
      dec0 = we0 & pend_q[bus.wrAddr0] & ~(iss && (bus.issueAddr == bus.wrAddr0));
      dec1 = we1 & pend_q[bus.wrAddr1] & ~(iss && (bus.issueAddr == bus.wrAddr1))
                 & ~(we0 && (bus.wrAddr0 == bus.wrAddr1));
      cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc}
                    - {{ADDR_W{1'b0}}, dec0}
                    - {{ADDR_W{1'b0}}, dec1};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.pendingCount = cnt_q;

   // Read ports
   logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]             rd_pend;

   assign rd_addr[0] = bus.rs;
   assign rd_addr[1] = bus.rt;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      regfile_scoreboard_rdport #(
         .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
      ) u_rd (
         .addr_i  (rd_addr[i]),
         .stored_i(mem_q[rd_addr[i]]),
         .pend_i  (pend_q[rd_addr[i]]),
         .we0_i   (we0),
         .wa0_i   (bus.wrAddr0),
         .wd0_i   (bus.wrData0),
         .we1_i   (we1),
         .wa1_i   (bus.wrAddr1),
         .wd1_i   (bus.wrData1),
         .data_o  (rd_data[i]),
         .pend_o  (rd_pend[i])
      );
   end

   assign bus.regA      = rd_data[0];
   assign bus.regB      = rd_data[1];
   assign bus.rsPending = rd_pend[0];
   assign bus.rtPending = rd_pend[1];
endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      int          cyc;
      logic [31:0] a, b;
      logic        pa, pb;
      logic [5:0]  cnt;
   } exp_t;

   exp_t q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model: architectural state only.
   logic [31:0] mm[32];
   bit          mp[32];

   task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc %0d: got %h expected %h", nm, c, act, exp);
      end
   endtask

   // Monitor: compares whatever the driver predicted for this cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("regA",         e.cyc, bus.regA,                e.a);
         chk("regB",         e.cyc, bus.regB,                e.b);
         chk("rsPending",    e.cyc, {31'b0, bus.rsPending},  {31'b0, e.pa});
         chk("rtPending",    e.cyc, {31'b0, bus.rtPending},  {31'b0, e.pb});
         chk("pendingCount", e.cyc, {26'b0, bus.pendingCount}, {26'b0, e.cnt});
      end
   end

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (bus.wrEn1 && bus.wrAddr1 == a) return bus.wrData1;
      if (bus.wrEn0 && bus.wrAddr0 == a) return bus.wrData0;
      return mm[a];
   endfunction

   function automatic logic m_pend(input logic [4:0] a);
      bit written;
      written = (bus.wrEn1 && bus.wrAddr1 == a && a != 0) ||
                (bus.wrEn0 && bus.wrAddr0 == a && a != 0);
      return mp[a] && !written;
   endfunction

   function automatic logic [5:0] m_count();
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(mp[i]);
      return 6'(n);
   endfunction

   task automatic step(input bit chk_en, input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                       input bit we0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit we1, input logic [4:0] a1, input logic [31:0] d1,
                       input bit ie, input logic [4:0] ia);
      exp_t e;
      reset = rst;
      bus.rs = rs; bus.rt = rt;
      bus.wrEn0 = we0; bus.wrAddr0 = a0; bus.wrData0 = d0;
      bus.wrEn1 = we1; bus.wrAddr1 = a1; bus.wrData1 = d1;
      bus.issueEn = ie; bus.issueAddr = ia;
      if (chk_en) begin
         e.cyc = cyc;
         e.a = m_read(rs);  e.b = m_read(rt);
         e.pa = m_pend(rs); e.pb = m_pend(rt);
         e.cnt = m_count();
         q.push_back(e);
      end
      // Advance the model to the state after this edge.
      if (rst) begin
         for (int i = 0; i < 32; i++) begin mm[i] = 32'h0; mp[i] = 1'b0; end
      end else begin
         if (we0 && a0 != 0) begin mm[a0] = d0; mp[a0] = 1'b0; end
         if (we1 && a1 != 0) begin mm[a1] = d1; mp[a1] = 1'b0; end
         if (ie && ia != 0) mp[ia] = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   initial begin
      reset = 1'b1;
      bus.rs = '0; bus.rt = '0;
      bus.wrEn0 = 0; bus.wrAddr0 = '0; bus.wrData0 = '0;
      bus.wrEn1 = 0; bus.wrAddr1 = '0; bus.wrData1 = '0;
      bus.issueEn = 0; bus.issueAddr = '0;
      @(posedge clk); #1;

      // Reset two cycles; storage is unknown until the first reset edge.
      step(0, 1, 9, 31, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 9, 31, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 9, 31, 0, 0, 0, 0, 0, 0, 0, 0);
      // Write then bypass, then stored value.
      step(1, 0, 9, 31, 1, 9, 32'hABCD1234, 0, 0, 0, 0, 0);
      step(1, 0, 9, 31, 0, 0, 0, 0, 0, 0, 0, 0);
      // Zero register on both ports plus issue to 0.
      step(1, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0);
      step(1, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
      // Dual-write conflict to 16.
      step(1, 0, 16, 16, 1, 16, 32'h11111111, 1, 16, 32'h22222222, 0, 0);
      step(1, 0, 16, 9, 0, 0, 0, 0, 0, 0, 0, 0);
      // Scoreboard sequence.
      step(1, 0, 16, 9, 0, 0, 0, 0, 0, 0, 1, 16);
      step(1, 0, 16, 9, 0, 0, 0, 0, 0, 0, 1, 9);
      step(1, 0, 16, 9, 1, 16, 32'h5A5A5A5A, 0, 0, 0, 0, 0);
      step(1, 0, 16, 9, 1, 9, 32'h0BADF00D, 0, 0, 0, 1, 9);
      step(1, 0, 16, 9, 0, 0, 0, 0, 0, 0, 1, 3);
      step(1, 0, 3, 9, 0, 0, 0, 0, 0, 0, 1, 4);
      // Reset mid-operation with issue and writes active (reads avoid written addresses).
      step(1, 1, 16, 9, 1, 5, 32'h77, 1, 6, 32'h88, 1, 7);
      step(1, 0, 16, 7, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0);

      // Randomized phase, biased to a small address window to force hits.
      for (int n = 0; n < 600; n++) begin
         logic [4:0] ad[6];
         bit rst, w0, w1, ie;
         for (int k = 0; k < 6; k++)
            ad[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         rst = ($urandom_range(0, 59) == 0);
         w0  = !rst && ($urandom_range(0, 2) == 0);
         w1  = !rst && ($urandom_range(0, 2) == 0);
         ie  = ($urandom_range(0, 1) == 0);
         step(1, rst, ad[0], ad[1], w0, ad[2], $urandom, w1, ad[3], $urandom, ie, ad[4]);
      end

      reset = 1'b0;
      bus.wrEn0 = 0; bus.wrEn1 = 0; bus.issueEn = 0;
      @(negedge clk); #1;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d entries left expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the pipeline's 32x32 register file. Provides two combinational read ports, two synchronous write ports with write-to-read bypass, a hardwired-zero register, and a per-register pending-write scoreboard that the decode stage uses for hazard detection. It sits between decode (read and issue) and writeback (write and clear) in the MIPS pipeline.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- BYPASS, 1, 1 = same-cycle write data forwarded to the read ports; 0 = read returns stored value only
- ZERO_REG, 1, 1 = register 0 reads 0, is never written and is never pending

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- rs  in  ADDR_W  read address A
- rt  in  ADDR_W  read address B
- regA  out  DATA_W  read data A, combinational
- regB  out  DATA_W  read data B, combinational
- rsPending  out  1  register rs has an outstanding producer
- rtPending  out  1  register rt has an outstanding producer
- wrEn0  in  1  write port 0 enable (ALU writeback)
- wrAddr0  in  ADDR_W  write port 0 address
- wrData0  in  DATA_W  write port 0 data
- wrEn1  in  1  write port 1 enable (memory/load writeback)
- wrAddr1  in  ADDR_W  write port 1 address
- wrData1  in  DATA_W  write port 1 data
- issueEn  in  1  mark issueAddr pending (instruction issued with a destination)
- issueAddr  in  ADDR_W  destination being issued
- pendingCount  out  ADDR_W+1  number of registers currently pending, registered

## Operation
- Storage: 2^ADDR_W x DATA_W, written on the rising edge of clk. There are no negedge writes; bypass replaces the half-cycle write/read trick.
- Write priority: if both ports write the same address in the same cycle, port 1 wins for both storage and bypass.
- ZERO_REG=1: writes to address 0 are dropped, reads of 0 return 0, and issue to 0 is ignored.
- Read, per port (rs shown):
  - If BYPASS and wrEn1 and wrAddr1==rs (nonzero when ZERO_REG), return wrData1.
  - Else if BYPASS and the same condition holds on port 0, return wrData0.
  - Else return the stored value.
- Scoreboard: one pending bit per register.
  - A write on either port clears the bit for its address.
  - issueEn sets the bit for issueAddr.
  - If a set and a clear hit the same address in the same cycle, the set wins (a newer producer exists).
  - Writes to registers that are not pending are legal and leave the bit at 0.
- rsPending = pending[rs] & ~(BYPASS & write hit on rs this cycle). An issue in the same cycle does not affect rsPending until the next cycle. rtPending is identical.
- pendingCount tracks the popcount of the pending bits. It updates on each edge by +1, 0 or −1 per set/clear, so net change per cycle is within −2..+1. Increments and decrements apply only when the bit actually changes state.

## Timing
- Reset (synchronous, when reset=1 at the edge):
  - All registers go to 0, all pending bits to 0, and pendingCount to 0.
  - Reset has priority over writes and issues in the same cycle.
  - After reset, regA=regB=0 and rsPending=rtPending=0 for any address.
- Write latency: 1 edge to storage, 0 cycles to the read ports with BYPASS=1, 1 cycle with BYPASS=0.
- Issue latency: the pending bit and pendingCount are visible 1 cycle after the issueEn edge.
- Clear latency: rsPending drops in the same cycle as the write when BYPASS=1, and the cycle after when BYPASS=0.
- Reading during reset returns the pre-reset stored values; they become 0 after the reset edge.
- pendingCount never exceeds 2^ADDR_W−1 when ZERO_REG=1, or 2^ADDR_W when ZERO_REG=0, and never wraps.

## Test plan
- Reset then read: reset for 2 cycles, rs=9, rt=31 -> regA=regB=0, both pending=0, pendingCount=0.
- Write then bypass: wrEn0=1, wrAddr0=9, wrData0=ABCD1234 with rs=9 in the same cycle -> regA=ABCD1234 immediately (BYPASS=1). Next cycle with wrEn0=0 -> still ABCD1234. With BYPASS=0, regA shows the new value only after the edge.
- Zero register: write FFFFFFFF to address 0 on both ports and issue 0 -> regA=0, rsPending=0, pendingCount unchanged.
- Dual-write conflict: port0 writes 11111111 and port1 writes 22222222 to address 16 -> bypass and stored value are both 22222222.
- Scoreboard sequence:
  - Issue 16, then issue 9 -> pendingCount 1 then 2, rsPending=1 for rs=16.
  - Port-0 write to 16 -> rsPending=0 that cycle, pendingCount=1 next.
  - Issue 9 and write 9 in the same cycle -> bit 9 stays set, count stays 1.
- Reset mid-operation: with 3 pending and writes active, assert reset together with issueEn=1 -> next cycle pendingCount=0, all reads return 0, and the issue is ignored.
